usb_rw_sched: RTL and testbench
===============================

# usb_rw_sched

Transaction sequencer between the host-side read/write requesters and `protocol`. It arbitrates between one read and one write requester and turns each accepted request into two USB transactions. The first is an OUT to endpoint 4 carrying the memory page address. The second is an OUT to endpoint 8 carrying write data, or an IN from endpoint 8 returning read data. It drives `protocol`'s `transaction`/`data_in_avail`/token/data inputs and reports one completion status per request.

## Interface
- DEV_ADDR, 7'd5: USB device address placed in every token.
- WD_LIMIT, 10'd1023: cycles to wait for `pkt_sent` before aborting a phase.
- clk  input  1  clock.
- rst_b  input  1  asynchronous active-low reset.
- read_req  input  1  read request (level); sampled only in IDLE.
- write_req  input  1  write request (level); sampled only in IDLE.
- mempage  input  16  target page; latched at accept.
- data_wr  input  64  write payload; latched at accept.
- busy  output  1  request in progress (accept+1 through FIN inclusive).
- done  output  1  one-cycle completion pulse.
- success  output  1  valid with `done`; 1 = both phases acknowledged.
- data_rd  output  64  read payload; updated only on a successful read.
- transaction  output  2  to protocol: 00 NON, 01 IN, 10 OUT.
- data_in_avail  output  1  to protocol: one-cycle start strobe.
- token_to_prot  output  19  {PID[7:0], DEV_ADDR[6:0], endp[3:0]}.
- data_to_prot  output  72  {DATA0 PID 8'hC3, payload[63:0]}.
- data_from_prot  input  64  read payload from protocol.
- pkt_sent  input  1  protocol finished current transaction.
- pkt_succeeded  input  1  valid with `pkt_sent`; transaction acknowledged.

## Operation
- PIDs: OUT 8'hE1, IN 8'h69. Address phase token {8'hE1, DEV_ADDR, 4'd4}; data phase token {8'hE1 or 8'h69, DEV_ADDR, 4'd8}.
- Address-phase payload {48'b0, mempage_q}; write data-phase payload data_wr_q; read data-phase `data_to_prot` = {8'hC3, 64'b0}.
- Arbitration in IDLE: single request granted; both asserted -> grant opposite of `last_write` (reg, reset 0, so first tie goes to write); `last_write` updated on every grant. Requests seen while busy are ignored (not queued).
- States: IDLE -> ADDR -> ADDR_WAIT -> GAP -> DATA -> DATA_WAIT -> FIN -> IDLE.
- IDLE: transaction=NON; on grant latch op/mempage/data_wr, go ADDR.
- ADDR: transaction=OUT, address token/payload, data_in_avail=1; go ADDR_WAIT.
- ADDR_WAIT: transaction=OUT held, data_in_avail=0. On pkt_sent: pkt_succeeded -> GAP; else -> FIN with fail.
- GAP: transaction=NON for exactly one cycle so protocol's controllers return to idle; go DATA.
- DATA: transaction=OUT (write) or IN (read), endpoint-8 token, data_in_avail=1; go DATA_WAIT.
- DATA_WAIT: transaction held. On pkt_sent -> FIN, success_q = pkt_succeeded. If read and pkt_succeeded, data_rd <= data_from_prot on the same edge.
- FIN: done=1, success=success_q, transaction=NON, busy=1; go IDLE.
- Watchdog: 10-bit counter cleared in ADDR/DATA, increments in *_WAIT. At WD_LIMIT without pkt_sent -> FIN with success=0. pkt_sent in the same cycle as the limit wins.
- token_to_prot/data_to_prot held stable from ADDR through ADDR_WAIT and from DATA through DATA_WAIT.

## Timing
- Reset (async, any state): state IDLE, transaction=00, data_in_avail=0, busy=0, done=0, success=0, data_rd=0, token/data outputs 0, last_write=0, watchdog=0.
- Request seen in IDLE at edge N -> ADDR (data_in_avail=1) during cycle N+1.
- Minimum latency, with pkt_sent arriving in the first WAIT cycle each phase: ADDR, ADDR_WAIT, GAP, DATA, DATA_WAIT, FIN = done 6 cycles after grant edge.
- Address failure: FIN follows ADDR_WAIT directly; the data phase is never issued.
- done is never asserted for two consecutive cycles. A new grant is possible in the cycle after FIN. A request held continuously is therefore re-accepted; requesters must deassert on done.
- pkt_sent outside *_WAIT states is ignored.
- All outputs registered or decoded from state only; no combinational path from data_from_prot to data_rd.

## Test plan
- Write, mempage=16'h0042, data_wr=64'hDEAD_BEEF_0123_4567, pkt_sent+pkt_succeeded 3 cycles into each WAIT -> ADDR token {E1,05,4} payload 0042; DATA token {E1,05,8} payload DEADBEEF01234567; one GAP cycle with transaction=00; done=1, success=1.
- Read, mempage=16'h0007, data_from_prot=64'h1122_3344_5566_7788 with success -> data phase transaction=01, token {69,05,8}; data_rd=1122334455667788 at done, success=1.
- Address phase NAK (pkt_sent=1, pkt_succeeded=0) -> no DATA state; done+success=0 the next cycle; data_rd unchanged.
- read_req and write_req asserted together twice in a row -> write granted first, read second. Failed read data phase leaves data_rd unchanged.
- pkt_sent never asserted in DATA_WAIT -> done with success=0 exactly WD_LIMIT cycles after entering DATA_WAIT; transaction returns to 00.
- rst_b pulsed low mid-DATA_WAIT -> immediately transaction=00, busy=0, data_rd=0; a new write after reset completes normally.

Source files
------------

// File: rtl/usb_rw_sched_if.sv
// usb_rw_sched_if: host request/status and protocol transaction signals of the sequencer
interface usb_rw_sched_if;
    logic        read_req;
    logic        write_req;
    logic [15:0] mempage;
    logic [63:0] data_wr;
    logic        busy;
    logic        done;
    logic        success;
    logic [63:0] data_rd;
    logic [1:0]  transaction;
    logic        data_in_avail;
    logic [18:0] token_to_prot;
    logic [71:0] data_to_prot;
    logic [63:0] data_from_prot;
    logic        pkt_sent;
    logic        pkt_succeeded;
    modport master (
        output read_req, write_req, mempage, data_wr, data_from_prot, pkt_sent, pkt_succeeded,
        input  busy, done, success, data_rd, transaction, data_in_avail, token_to_prot, data_to_prot
    );
    modport slave (
        input  read_req, write_req, mempage, data_wr, data_from_prot, pkt_sent, pkt_succeeded,
        output busy, done, success, data_rd, transaction, data_in_avail, token_to_prot, data_to_prot
    );
endinterface

// File: rtl/usb_rw_sched.sv
// usb_rw_sched: arbitrates read/write requests and issues address + data USB transactions
module usb_rw_sched #(
    parameter logic [6:0] DEV_ADDR = 7'd5,
    parameter logic [9:0] WD_LIMIT = 10'd1023
) (
    input logic clk,
    input logic rst_b,
    usb_rw_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_WAIT, GAP, DATA, DATA_WAIT, FIN} state_t;
    state_t      state, state_nx;
    logic        op_wr, last_write, success_q, grant, grant_wr, wd_exp;
    logic [9:0]  wd;
    logic [63:0] data_wr_q;
    assign grant    = bus.read_req || bus.write_req;
    assign grant_wr = bus.write_req && (!bus.read_req || !last_write);
    assign wd_exp   = wd == WD_LIMIT - 10'd1;
    // state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end
    // next state: pkt_sent is checked before the watchdog so it wins a same-cycle race
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = grant ? ADDR : IDLE;
            ADDR:      state_nx = ADDR_WAIT;
            ADDR_WAIT: state_nx = bus.pkt_sent ? (bus.pkt_succeeded ? GAP : FIN) : wd_exp ? FIN : ADDR_WAIT;
            GAP:       state_nx = DATA;
            DATA:      state_nx = DATA_WAIT;
            DATA_WAIT: state_nx = (bus.pkt_sent || wd_exp) ? FIN : DATA_WAIT;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    // outputs decoded from state only
    always_comb begin
        bus.transaction   = (state == ADDR || state == ADDR_WAIT) ? 2'b10 :
                            (state == DATA || state == DATA_WAIT) ? (op_wr ? 2'b10 : 2'b01) : 2'b00;
        bus.data_in_avail = state == ADDR || state == DATA;
        bus.busy          = state != IDLE;
        bus.done          = state == FIN;
        bus.success       = state == FIN && success_q;
    end
    // request latching, token/payload staging, watchdog and completion status
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_wr             <= 1'b0;
            last_write        <= 1'b0;
            success_q         <= 1'b0;
            wd                <= '0;
            data_wr_q         <= '0;
            bus.data_rd       <= '0;
            bus.token_to_prot <= '0;
            bus.data_to_prot  <= '0;
        end else begin
            wd <= (state == ADDR_WAIT || state == DATA_WAIT) ? wd + 10'd1 : '0;
            if (state == IDLE && grant) begin
                op_wr             <= grant_wr;
                last_write        <= grant_wr;
                data_wr_q         <= bus.data_wr;
                bus.token_to_prot <= {8'hE1, DEV_ADDR, 4'd4};
                bus.data_to_prot  <= {8'hC3, 48'h0, bus.mempage};
            end
            if (state == GAP) begin
                bus.token_to_prot <= {op_wr ? 8'hE1 : 8'h69, DEV_ADDR, 4'd8};
                bus.data_to_prot  <= {8'hC3, op_wr ? data_wr_q : 64'h0};
            end
            if (state == ADDR_WAIT) success_q <= 1'b0;
            if (state == DATA_WAIT) success_q <= bus.pkt_sent && bus.pkt_succeeded;
            if (state == DATA_WAIT && bus.pkt_sent && bus.pkt_succeeded && !op_wr) bus.data_rd <= bus.data_from_prot;
        end
    end
endmodule

// File: tb/tb_usb_rw_sched.sv
// tb_usb_rw_sched: scoreboard bench with a protocol responder for usb_rw_sched
module tb_usb_rw_sched;
    localparam logic [6:0] DEV = 7'd5;
    localparam int WD = 1023;
    typedef struct packed {logic [1:0] tr; logic [18:0] tok; logic [71:0] dat;} ph_t;
    typedef struct packed {logic ok; logic [63:0] rd;} cmp_t;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    usb_rw_sched_if bus();
    usb_rw_sched dut (.clk(clk), .rst_b(rst_b), .bus(bus));
    always #5 clk = ~clk;
    int nvec = 0, nerr = 0, cyc = 0, done_cnt = 0, done_cyc = 0, addr_cyc = 0, data_cyc = 0, gap_cnt = 0;
    int dly [2];
    logic ok_c [2];
    logic [63:0] rdata_c, m_rd;
    logic m_last_wr, prev_done;
    logic [18:0] cur_tok;
    logic [71:0] cur_dat;
    ph_t ph_q[$];
    cmp_t cmp_q[$];
    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // monitor: phase strobes, token hold, GAP length, completions
    initial begin
        ph_t p;
        cmp_t c;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.done) chk("done_pair", 72'(prev_done), 72'(0));
            prev_done = bus.done;
            if (bus.data_in_avail) begin
                if (bus.token_to_prot[3:0] == 4'd8) begin
                    chk("gap_len", 72'(gap_cnt), 72'(1));
                    data_cyc = cyc;
                end else addr_cyc = cyc;
                if (ph_q.size() == 0) chk("phase_unexp", 72'(bus.transaction), 72'(0));
                else begin
                    p = ph_q.pop_front();
                    chk("trans", 72'(bus.transaction), 72'(p.tr));
                    chk("token", 72'(bus.token_to_prot), 72'(p.tok));
                    chk("payload", bus.data_to_prot, p.dat);
                end
                cur_tok = bus.token_to_prot;
                cur_dat = bus.data_to_prot;
            end else if (bus.transaction != 2'b00) begin
                chk("tok_hold", 72'(bus.token_to_prot), 72'(cur_tok));
                chk("dat_hold", bus.data_to_prot, cur_dat);
            end
            gap_cnt = (bus.busy && bus.transaction == 2'b00) ? gap_cnt + 1 : 0;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("fin_trans", 72'(bus.transaction), 72'(0));
                if (cmp_q.size() == 0) chk("done_unexp", 72'(bus.done), 72'(0));
                else begin
                    c = cmp_q.pop_front();
                    chk("success", 72'(bus.success), 72'(c.ok));
                    chk("data_rd", 72'(bus.data_rd), 72'(c.rd));
                end
            end
        end
    end
    // protocol responder: answers each strobe after dly cycles, never when dly < 0
    initial begin
        int ph;
        forever begin
            @(posedge clk);
            #1;
            if (bus.data_in_avail) begin
                ph = (bus.token_to_prot[3:0] == 4'd8) ? 1 : 0;
                if (dly[ph] >= 0) begin
                    repeat (dly[ph]) @(posedge clk);
                    #1;
                    bus.pkt_sent = 1'b1;
                    bus.pkt_succeeded = ok_c[ph];
                    bus.data_from_prot = rdata_c;
                    @(posedge clk);
                    #1;
                    bus.pkt_sent = 1'b0;
                    bus.pkt_succeeded = 1'b0;
                end
            end
        end
    end
    task automatic push_req(input logic gw, input logic [15:0] page, input logic [63:0] wdat,
                            input int ad, input logic aok, input int dd, input logic dok, input logic [63:0] rdv);
        dly[0] = ad; ok_c[0] = aok; dly[1] = dd; ok_c[1] = dok; rdata_c = rdv;
        ph_q.push_back({2'b10, 8'hE1, DEV, 4'd4, 8'hC3, 48'h0, page});
        if (ad >= 0 && aok) ph_q.push_back({gw ? 2'b10 : 2'b01, gw ? 8'hE1 : 8'h69, DEV, 4'd8, 8'hC3, gw ? wdat : 64'h0});
        if (ad >= 0 && aok && dd >= 0 && dok && !gw) m_rd = rdv;
        cmp_q.push_back({ad >= 0 && aok && dd >= 0 && dok, m_rd});
    endtask
    task automatic drive(input logic wr, input logic rd, input logic [15:0] page, input logic [63:0] wdat, output int g);
        @(posedge clk);
        #1;
        bus.write_req = wr; bus.read_req = rd; bus.mempage = page; bus.data_wr = wdat;
        @(posedge clk);
        #1;
        g = cyc;
        bus.write_req = 1'b0; bus.read_req = 1'b0; bus.mempage = ~page; bus.data_wr = ~wdat;
        chk("busy", 72'(bus.busy), 72'(1));
    endtask
    task automatic req(input logic wr, input logic rd, input logic [15:0] page, input logic [63:0] wdat,
                       input int ad, input logic aok, input int dd, input logic dok, input logic [63:0] rdv, output int lat);
        logic gw;
        int n, d0, g;
        gw = wr && (!rd || !m_last_wr);
        m_last_wr = gw;
        push_req(gw, page, wdat, ad, aok, dd, dok, rdv);
        d0 = done_cnt;
        drive(wr, rd, page, wdat, g);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 72'(bus.done), 72'(1));
        lat = done_cyc - g + 1;
    endtask
    initial begin
        int lat, n, d0, g;
        bus.read_req = 0; bus.write_req = 0; bus.mempage = 0; bus.data_wr = 0;
        bus.data_from_prot = 0; bus.pkt_sent = 0; bus.pkt_succeeded = 0;
        dly[0] = 1; dly[1] = 1; ok_c[0] = 1; ok_c[1] = 1; rdata_c = 0;
        m_rd = 0; m_last_wr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trans", 72'(bus.transaction), 72'(0));
        chk("rst_avail", 72'(bus.data_in_avail), 72'(0));
        chk("rst_busy", 72'(bus.busy), 72'(0));
        chk("rst_done", 72'(bus.done), 72'(0));
        chk("rst_success", 72'(bus.success), 72'(0));
        chk("rst_data_rd", 72'(bus.data_rd), 72'(0));
        chk("rst_token", 72'(bus.token_to_prot), 72'(0));
        chk("rst_data", bus.data_to_prot, 72'(0));
        rst_b = 1'b1;
        req(1, 0, 16'h0042, 64'hDEAD_BEEF_0123_4567, 4, 1, 4, 1, 64'h0, lat);
        req(0, 1, 16'h0007, 64'h0, 1, 1, 1, 1, 64'h1122_3344_5566_7788, lat);
        chk("latency_min", 72'(lat), 72'(6));
        req(0, 1, 16'h0100, 64'h0, 1, 0, 1, 1, 64'hFFFF_0000_FFFF_0000, lat);
        chk("nak_fin", 72'(done_cyc - addr_cyc), 72'(2));
        req(1, 1, 16'h0200, 64'hA5A5_A5A5_5A5A_5A5A, 2, 1, 2, 1, 64'h0, lat);
        req(1, 1, 16'h0201, 64'h0F0F_0F0F_0F0F_0F0F, 2, 1, 3, 0, 64'hBAD0_BAD0_BAD0_BAD0, lat);
        req(1, 0, 16'h0300, 64'h0123_4567_89AB_CDEF, 1, 1, -1, 1, 64'h0, lat);
        chk("wd_cycles", 72'(done_cyc - data_cyc - 1), 72'(WD));
        push_req(1'b1, 16'h0400, 64'hCAFE_F00D_CAFE_F00D, 1, 1, -1, 0, 64'h0);
        d0 = data_cyc;
        drive(1, 0, 16'h0400, 64'hCAFE_F00D_CAFE_F00D, g);
        n = 0;
        while (data_cyc == d0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_trans", 72'(bus.transaction), 72'(2'b10));
        #3;
        rst_b = 1'b0;
        #1;
        chk("arst_trans", 72'(bus.transaction), 72'(0));
        chk("arst_busy", 72'(bus.busy), 72'(0));
        chk("arst_data_rd", 72'(bus.data_rd), 72'(0));
        m_rd = 0; m_last_wr = 0;
        ph_q.delete();
        cmp_q.delete();
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        req(1, 0, 16'h0500, 64'h7766_5544_3322_1100, 1, 1, 1, 1, 64'h0, lat);
        chk("post_rst_lat", 72'(lat), 72'(6));
        chk("phase_q_drained", 72'(ph_q.size()), 72'(0));
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
